// File: rtl/exec_datapath_if.sv
// Instruction/result bus of the two-stage execute datapath.
// Carries the instruction handshake, the completion report, the flag
// register output and the debug register read port.
interface exec_datapath_if #(
    parameter int DATA_W = 32,
    parameter int NREG   = 16
);
    localparam int AW      = $clog2(NREG);
    localparam int INSTR_W = 3 + 3 * AW;

    logic               in_valid;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr;
    logic               res_valid;
    logic               res_we;
    logic [AW-1:0]      res_rd;
    logic [DATA_W-1:0]  res_data;
    logic [3:0]         flags;
    logic [AW-1:0]      dbg_addr;
    logic [DATA_W-1:0]  dbg_data;

    // Instruction source (sequencer side)
    modport master (
        output in_valid, in_instr, dbg_addr,
        input  in_ready, res_valid, res_we, res_rd, res_data, flags, dbg_data
    );

    // Datapath side
    modport slave (
        input  in_valid, in_instr, dbg_addr,
        output in_ready, res_valid, res_we, res_rd, res_data, flags, dbg_data
    );
endinterface

// File: rtl/exec_datapath.sv
// Two-stage execute datapath: register file read (stage 1) feeding an ALU
// with writeback and NZCV flag update (stage 2).
// Optional feature macro: EXEC_FWD_EN
//   defined   - RAW hazards are resolved by forwarding the stage-2 result,
//               in_ready is always 1.
//   undefined - RAW hazards stall the incoming instruction for one cycle.
module exec_datapath #(
    parameter int DATA_W = 32,
    parameter int NREG   = 16
) (
    input logic             clk,
    input logic             reset,
    exec_datapath_if.slave  bus
);
    localparam int AW      = $clog2(NREG);
    localparam int INSTR_W = 3 + 3 * AW;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_SLT = 3'b101,
        OP_CMP = 3'b110,
        OP_MOV = 3'b111
    } op_e;

    // Architectural and pipeline state
    logic [DATA_W-1:0] regs_q [NREG];
    logic              v2_q;
    op_e               op_q;
    logic [AW-1:0]     rd_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic              res_valid_q, res_we_q;
    logic [AW-1:0]     res_rd_q;
    logic [DATA_W-1:0] res_data_q;
    logic [3:0]        flags_q;

    // Incoming instruction fields
    op_e           in_op;
    logic [AW-1:0] in_rd, in_rs1, in_rs2;

    assign in_op  = op_e'(bus.in_instr[INSTR_W-1 -: 3]);
    assign in_rd  = bus.in_instr[3*AW-1 -: AW];
    assign in_rs1 = bus.in_instr[2*AW-1 -: AW];
    assign in_rs2 = bus.in_instr[AW-1:0];

    // Stage-2 ALU: result, flags and write enable
    logic [DATA_W-1:0] res_data_d;
    logic [3:0]        flags_d;
    logic              writes_d;
    logic              is_sub;
    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   sum;
    logic              carry, ovf;
    logic              wb_en;

    // ALU evaluation of the instruction held in stage 2
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value
        // unassigned, which would otherwise infer a latch.
        is_sub     = (op_q == OP_SUB) || (op_q == OP_CMP);
        b_eff      = is_sub ? ~b_q : b_q;
        sum        = {1'b0, a_q} + {1'b0, b_eff} + {{DATA_W{1'b0}}, is_sub};
        res_data_d = sum[DATA_W-1:0];
        carry      = 1'b0;
        ovf        = 1'b0;
        writes_d   = (op_q != OP_CMP);
        case (op_q)
            OP_ADD, OP_SUB, OP_CMP: begin
                carry = sum[DATA_W];
                ovf   = (a_q[DATA_W-1] == b_eff[DATA_W-1]) &&
                        (sum[DATA_W-1] != a_q[DATA_W-1]);
            end
            OP_AND:  res_data_d = a_q & b_q;
            OP_OR:   res_data_d = a_q | b_q;
            OP_XOR:  res_data_d = a_q ^ b_q;
            OP_SLT:  res_data_d = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            OP_MOV:  res_data_d = b_q;
            default: ;
        endcase
        flags_d = {res_data_d[DATA_W-1], ~|res_data_d, carry, ovf};
    end

    assign wb_en = v2_q && writes_d;

    // Stage-1 operand read with write-through of the result retiring this edge
    logic [DATA_W-1:0] op_a_d, op_b_d;

    always_comb begin
        op_a_d = regs_q[in_rs1];
        op_b_d = regs_q[in_rs2];
        if (wb_en && (rd_q == in_rs1)) op_a_d = res_data_d;
        if (wb_en && (rd_q == in_rs2)) op_b_d = res_data_d;
    end

    // Handshake: forwarding makes every instruction acceptable; otherwise
    // a RAW dependency on the stage-2 instruction holds it for one cycle.
    logic accept;
`ifdef EXEC_FWD_EN
    assign bus.in_ready = 1'b1;
`else
    logic hazard;
    assign hazard       = wb_en && ((rd_q == in_rs1) || (rd_q == in_rs2));
    assign bus.in_ready = reset || !hazard;
`endif
    assign accept = bus.in_valid && bus.in_ready && !reset;

    // Pipeline, register file and result/flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the register file is reset element by element because each
            // register must come up holding its own index; this keeps it in
            // flops rather than a RAM macro.
            for (int i = 0; i < NREG; i++) regs_q[i] <= DATA_W'(i);
            v2_q        <= 1'b0;
            op_q        <= OP_ADD;
            rd_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_valid_q <= 1'b0;
            res_we_q    <= 1'b0;
            res_rd_q    <= '0;
            res_data_q  <= '0;
            flags_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, regardless of statement order.
            v2_q <= accept;
            if (accept) begin
                op_q <= in_op;
                rd_q <= in_rd;
                a_q  <= op_a_d;
                b_q  <= op_b_d;
            end
            if (wb_en) regs_q[rd_q] <= res_data_d;
            res_valid_q <= v2_q;
            res_we_q    <= wb_en;
            if (v2_q) begin
                res_rd_q   <= rd_q;
                res_data_q <= res_data_d;
                flags_q    <= flags_d;
            end
        end
    end

    assign bus.res_valid = res_valid_q;
    assign bus.res_we    = res_we_q;
    assign bus.res_rd    = res_rd_q;
    assign bus.res_data  = res_data_q;
    assign bus.flags     = flags_q;
    assign bus.dbg_data  = regs_q[bus.dbg_addr];
endmodule

// File: tb/tb_exec_datapath.sv
// Self-checking bench for exec_datapath. A 32-bit and an 8-bit instance are
// driven with the same instruction stream; an architectural model (plain
// integer arithmetic, sequential semantics) predicts every completion.
module tb_exec_datapath;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [14:0] in_instr;
    logic [3:0]  dbg_addr;

    always #5 clk = ~clk;

    exec_datapath_if #(.DATA_W(32), .NREG(16)) bus32 ();
    exec_datapath_if #(.DATA_W(8),  .NREG(16)) bus8 ();

    assign bus32.in_valid = in_valid;
    assign bus32.in_instr = in_instr;
    assign bus32.dbg_addr = dbg_addr;
    assign bus8.in_valid  = in_valid;
    assign bus8.in_instr  = in_instr;
    assign bus8.dbg_addr  = dbg_addr;

    exec_datapath #(.DATA_W(32), .NREG(16)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
    exec_datapath #(.DATA_W(8),  .NREG(16)) dut8  (.clk(clk), .reset(reset), .bus(bus8));

    typedef struct {
        logic        we;
        logic [3:0]  rd;
        logic [63:0] data;
        logic [3:0]  flg;
        int          due;
    } exp_t;

    exp_t   q [2][$];
    longint mregs [2][16];
    int     n_checks = 0;
    int     n_pass   = 0;
    int     cyc      = 0;
    int     last_acc_edge = -10;
    logic   last_we  = 1'b0;
    int     last_rd  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int wid(input int k);
        return (k == 0) ? 32 : 8;
    endfunction

    function automatic logic out_of_range(input longint s, input int w);
        return (s > ((longint'(1) << (w - 1)) - 1)) || (s < -(longint'(1) << (w - 1)));
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 16; r++) mregs[k][r] = r;
    endfunction

    // Architectural execution of one instruction on model k
    function automatic void model_exec(input int k, input logic [2:0] op,
                                       input int rd, input int rs1, input int rs2, input int due);
        longint w, mask, a, b, sa, sb, r;
        logic   c, v;
        exp_t   e;
        w    = wid(k);
        mask = (longint'(1) << w) - 1;
        a    = mregs[k][rs1];
        b    = mregs[k][rs2];
        sa   = (a >= (longint'(1) << (w - 1))) ? a - (longint'(1) << w) : a;
        sb   = (b >= (longint'(1) << (w - 1))) ? b - (longint'(1) << w) : b;
        c = 1'b0;
        v = 1'b0;
        r = 0;
        case (op)
            3'd0: begin r = (a + b) & mask; c = (a + b) > mask; v = out_of_range(sa + sb, w); end
            3'd1, 3'd6: begin r = (a - b) & mask; c = (a >= b); v = out_of_range(sa - sb, w); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            3'd5: r = (sa < sb) ? 1 : 0;
            default: r = b;
        endcase
        e.we   = (op != 3'd6);
        e.rd   = 4'(rd);
        e.data = r;
        e.flg  = {((r >> (w - 1)) & 1) != 0, r == 0, c, v};
        e.due  = due;
        if (e.we) mregs[k][rd] = r;
        q[k].push_back(e);
    endfunction

    task automatic mon(input int k, input logic v, input logic we, input logic [3:0] rd,
                       input logic [63:0] data, input logic [3:0] flg);
        exp_t e;
        logic exp_v;
        exp_v = (q[k].size() > 0) && (q[k][0].due == cyc);
        check($sformatf("res_valid[%0d] cyc%0d", k, cyc), v, exp_v);
        if (exp_v) begin
            e = q[k].pop_front();
            check($sformatf("res_we[%0d]", k), we, e.we);
            check($sformatf("res_rd[%0d]", k), rd, e.rd);
            check($sformatf("res_data[%0d]", k), data, e.data);
            check($sformatf("flags[%0d]", k), flg, e.flg);
        end
    endtask

    // One clock edge, then compare both instances' completion outputs
    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        mon(0, bus32.res_valid, bus32.res_we, bus32.res_rd, 64'(bus32.res_data), bus32.flags);
        mon(1, bus8.res_valid, bus8.res_we, bus8.res_rd, 64'(bus8.res_data), bus8.flags);
    endtask

    task automatic send(input logic [2:0] op, input int rd, input int rs1, input int rs2);
        logic acc;
        logic hz;
        int   stalls;
        int   exp_stalls;
        hz = (last_acc_edge == cyc) && last_we && (last_rd == rs1 || last_rd == rs2);
`ifdef EXEC_FWD_EN
        exp_stalls = 0;
`else
        exp_stalls = hz ? 1 : 0;
`endif
        in_valid = 1'b1;
        in_instr = {op, 4'(rd), 4'(rs1), 4'(rs2)};
        stalls   = 0;
        acc      = 1'b0;
        for (int t = 0; t < 4 && !acc; t++) begin
            #1;
            check("in_ready32", bus32.in_ready, (stalls < exp_stalls) ? 1'b0 : 1'b1);
            check("in_ready8",  bus8.in_ready,  (stalls < exp_stalls) ? 1'b0 : 1'b1);
            if (bus32.in_ready) begin
                acc = 1'b1;
                model_exec(0, op, rd, rs1, rs2, cyc + 2);
                model_exec(1, op, rd, rs1, rs2, cyc + 2);
                last_acc_edge = cyc + 1;
                last_we       = (op != 3'd6);
                last_rd       = rd;
            end else begin
                stalls++;
            end
            tick();
        end
        in_valid = 1'b0;
        if (!acc) check("accept_timeout", 64'd0, 64'd1);
        check("stall_cycles", 64'(stalls), 64'(exp_stalls));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_instr = 15'($urandom);
        repeat (n) tick();
    endtask

    task automatic drain();
        for (int t = 0; t < 8 && (q[0].size() > 0 || q[1].size() > 0); t++) tick();
        check("drain_q32", 64'(q[0].size()), 64'd0);
        check("drain_q8",  64'(q[1].size()), 64'd0);
    endtask

    // Read a register through the debug port and compare with constants
    task automatic dbg_expect(input int r, input logic [63:0] v32, input logic [63:0] v8);
        dbg_addr = 4'(r);
        tick();
        check($sformatf("dbg32 r%0d", r), 64'(bus32.dbg_data), v32);
        check($sformatf("dbg8 r%0d", r),  64'(bus8.dbg_data),  v8);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        q[0].delete();
        q[1].delete();
        model_reset();
        last_acc_edge = -10;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_instr = '0;
        dbg_addr = '0;

        // 1: reset state, in_ready high and nothing accepted during reset
        model_reset();
        in_valid = 1'b1;
        in_instr = {3'd0, 4'd9, 4'd1, 4'd1};
        #1;
        check("ready_in_reset32", bus32.in_ready, 1'b1);
        check("ready_in_reset8",  bus8.in_ready,  1'b1);
        do_reset();
        check("rst_flags32", bus32.flags, 4'b0000);
        check("rst_flags8",  bus8.flags,  4'b0000);
        dbg_expect(9, 64'd9, 64'd9);
        dbg_expect(5, 64'd5, 64'd5);
        send(3'd0, 3, 1, 2);
        drain();
        check("add_flags32", bus32.flags, 4'b0000);
        dbg_expect(3, 64'd3, 64'd3);

        // 2: SUB to zero and CMP producing a borrow
        send(3'd1, 4, 5, 5);
        drain();
        check("sub_flags32", bus32.flags, 4'b0110);
        check("sub_flags8",  bus8.flags,  4'b0110);
        send(3'd6, 0, 2, 3);
        drain();
        check("cmp_flags32", bus32.flags, 4'b1000);
        check("cmp_flags8",  bus8.flags,  4'b1000);
        dbg_expect(2, 64'd2, 64'd2);
        dbg_expect(3, 64'd3, 64'd3);

        // 3: back-to-back dependent instructions
        send(3'd0, 1, 2, 3);
        send(3'd0, 4, 1, 1);
        drain();
        dbg_expect(1, 64'd5, 64'd5);
        dbg_expect(4, 64'd10, 64'd10);

        // 4: 8-bit overflow and carry sequence on r15
        do_reset();
        for (int i = 0; i < 4; i++) send(3'd0, 15, 15, 15);
        drain();
        check("ovf_flags8", bus8.flags, 4'b1001);
        dbg_expect(15, 64'd240, 64'd240);
        send(3'd0, 15, 15, 15);
        drain();
        check("carry_flags8", bus8.flags, 4'b1010);
        dbg_expect(15, 64'd480, 64'hE0);

        // 5: SLT both directions, MOV, XOR to zero
        send(3'd5, 6, 14, 1);
        drain();
        dbg_expect(6, 64'd0, 64'd0);
        send(3'd5, 6, 1, 14);
        drain();
        dbg_expect(6, 64'd1, 64'd1);
        send(3'd7, 7, 0, 9);
        drain();
        dbg_expect(7, 64'd9, 64'd9);
        send(3'd4, 8, 8, 8);
        drain();
        check("xor_flags32", bus32.flags, 4'b0100);
        dbg_expect(8, 64'd0, 64'd0);

        // 6: instruction in flight when reset arrives is dropped
        send(3'd0, 7, 1, 1);
        reset = 1'b1;
        q[0].delete();
        q[1].delete();
        model_reset();
        last_acc_edge = -10;
        tick();
        reset = 1'b0;
        check("inflight_flags32", bus32.flags, 4'b0000);
        check("inflight_flags8",  bus8.flags,  4'b0000);
        dbg_expect(7, 64'd7, 64'd7);

        // 7: randomized stream with idle gaps, checked against the model
        for (int n = 0; n < 300; n++) begin
            int lim;
            lim = ($urandom_range(0, 1) == 0) ? 3 : 15;
            send(3'($urandom_range(0, 7)), $urandom_range(0, lim),
                 $urandom_range(0, lim), $urandom_range(0, lim));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        drain();
        for (int r = 0; r < 16; r++)
            dbg_expect(r, 64'(mregs[0][r]), 64'(mregs[1][r]));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
